flopenr_stream_reader: RTL

- Read-side companion to the enabled register (flopenr): captures each word presented on d while en is high and buffers it in a small first-word-fall-through FIFO.
- Drains the buffered words to a downstream consumer through a valid/ready handshake.
- Sits between an enabled-register write stream and any slower reader.
- Reports occupancy and a sticky overflow flag.

---
 rtl/flopenr_stream_reader.sv | 93 +++++++++
 1 files changed

// File: rtl/flopenr_stream_reader.sv
// flopenr_stream_reader
//   Read-side companion to an enabled register. Every word presented on d while
//   en is high is captured into a small first-word-fall-through FIFO. The words
//   are then drained to a consumer through a valid/ready handshake.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   en        write enable; d is captured on a rising clk edge when en=1
//   d         write data
//   rd_ready  consumer accepts q this cycle
//   q         head-of-FIFO data; reads 0 while the FIFO is empty
//   q_valid   FIFO non-empty
//   full      count == DEPTH
//   count     number of stored words, 0..DEPTH
//   overflow  sticky; set when a write was dropped, cleared only by rst
//
// DEPTH must be a power of 2 (minimum 2), and ADDR_W must equal log2(DEPTH).
// Because of this, the pointers wrap DEPTH-1 -> 0 through plain binary overflow.
module flopenr_stream_reader #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  d,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  q,
  output logic              q_valid,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_r;
  logic              overflow_r;
  logic              rd_fire;
  logic              wr_fire;

  assign q_valid  = (count_r != '0);
  assign full     = (count_r == DEPTH_C);
  assign count    = count_r;
  assign overflow = overflow_r;

  // When the FIFO is full, a simultaneous read frees the slot that the write
  // needs, so the write is still accepted.
  assign rd_fire = rd_ready && q_valid;
  assign wr_fire = en && (!full || rd_fire);

  // The head is read straight from storage, so there is no added read latency.
  // It is gated with q_valid, so q reads 0 after reset even though the memory
  // contents are undefined at that point.
  assign q = q_valid ? mem[rd_ptr] : '0;

  // The storage array is not reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_fire && !rd_fire) begin
        count_r <= count_r + 1'b1;
      end else if (rd_fire && !wr_fire) begin
        count_r <= count_r - 1'b1;
      end
      if (en && !wr_fire) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule
